// File: rtl/regfile_pkg.sv
// Shared defaults and address-range helper for the 2R1W register bank.
package regfile_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int NUM_RD    = 2;

  // True when addr selects an implemented word.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for the 2R1W register bank: control, write port, two read ports, error flag.
interface regfile_2r1w_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic              en;
  logic              clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              err;

  modport master (
    output en, clr, we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, err
  );

  modport slave (
    input  en, clr, we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, err
  );
endinterface

// File: rtl/regfile_rdport.sv
// One read port: word select, out-of-range zeroing, write-first bypass, output register.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic                         wr_ok,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] rd_nxt;

  // Select the addressed word; unmatched (out-of-range) and hard-zero addresses read 0.
  // wr_ok already excludes invalid and hard-zero targets, so the bypass needs only the address match.
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      if (raddr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) rd_nxt = mem[i];
    if (wr_ok && waddr == raddr) rd_nxt = wdata;
  end

  // Output register: cleared by rst/clr, otherwise updates only while enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) rdata <= '0;
    else if (en)    rdata <= rd_nxt;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH flop-based register bank with one write port and two registered read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 0
) (
  input logic           clk,
  input logic           rst,
  regfile_2r1w_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic                         err_q;
  logic                         in_rng;
  logic                         wr_ok;
  logic                         wr_bad;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][WIDTH-1:0]  rdata;

  assign in_rng = addr_in_range(32'(bus.waddr), DEPTH);
  // Word 0 is silently read-only under ZERO_REG; this is not an error.
  assign wr_ok  = bus.en && bus.we && in_rng && !(ZERO_REG != 0 && bus.waddr == '0);
  assign wr_bad = bus.en && bus.we && !in_rng;

  // Storage and sticky error: rst clears both, clr clears words only and drops the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      err_q <= 1'b0;
    end else if (bus.clr) begin
      mem   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && bus.waddr == ADDR_W'(i)) mem[i] <= bus.wdata;
      if (wr_bad) err_q <= 1'b1;
    end
  end

  assign raddr       = {bus.raddr_b, bus.raddr_a};
  assign bus.rdata_a = rdata[0];
  assign bus.rdata_b = rdata[1];
  assign bus.err     = err_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clr),
      .en    (bus.en),
      .mem   (mem),
      .raddr (raddr[p]),
      .wr_ok (wr_ok),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .rdata (rdata[p])
    );
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench: two banks (DEPTH 8 plain, DEPTH 6 with hard-zero word 0) on shared stimulus,
// checked against a per-bank scoreboard model.
module tb_regfile_2r1w;
  import regfile_pkg::*;

  localparam int unsigned DEP [2] = '{8, 6};
  localparam bit          ZR  [2] = '{1'b0, 1'b1};

  typedef struct {
    int         dut;
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_2r1w_if #(.WIDTH(8), .DEPTH(8)) b0 ();
  regfile_2r1w_if #(.WIDTH(8), .DEPTH(6)) b1 ();

  regfile_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  regfile_2r1w #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [7:0] m   [2][8];
  logic [7:0] ma  [2];
  logic [7:0] mb  [2];
  logic       me  [2];
  exp_t       sb  [$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_step = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] rd_model(input int d, input logic [2:0] addr);
    if (!addr_in_range(32'(addr), DEP[d])) return 8'h00;
    if (ZR[d] && addr == 3'd0) return 8'h00;
    return m[d][addr];
  endfunction

  task automatic step(input logic r, input logic c, input logic e, input logic w,
                      input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] ra, input logic [2:0] rb);
    exp_t x;
    logic ok;
    @(negedge clk);
    rst = r;
    b0.clr = c; b0.en = e; b0.we = w; b0.waddr = wa; b0.wdata = wd; b0.raddr_a = ra; b0.raddr_b = rb;
    b1.clr = c; b1.en = e; b1.we = w; b1.waddr = wa; b1.wdata = wd; b1.raddr_a = ra; b1.raddr_b = rb;
    for (int d = 0; d < 2; d++) begin
      ok = w && addr_in_range(32'(wa), DEP[d]) && !(ZR[d] && wa == 3'd0);
      if (r) begin
        for (int i = 0; i < 8; i++) m[d][i] = 8'h00;
        ma[d] = 8'h00; mb[d] = 8'h00; me[d] = 1'b0;
      end else if (c) begin
        for (int i = 0; i < 8; i++) m[d][i] = 8'h00;
        ma[d] = 8'h00; mb[d] = 8'h00;
      end else if (e) begin
        ma[d] = (ok && wa == ra) ? wd : rd_model(d, ra);
        mb[d] = (ok && wa == rb) ? wd : rd_model(d, rb);
        if (ok) m[d][wa] = wd;
        if (w && !addr_in_range(32'(wa), DEP[d])) me[d] = 1'b1;
      end
      x.dut = d; x.tag = $sformatf("s%0d_d%0d", n_step, d);
      x.a = ma[d]; x.b = mb[d]; x.e = me[d];
      sb.push_back(x);
    end
    n_step++;
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.dut == 0) begin
        chk({x.tag, "_a"}, 32'(b0.rdata_a), 32'(x.a));
        chk({x.tag, "_b"}, 32'(b0.rdata_b), 32'(x.b));
        chk({x.tag, "_err"}, 32'(b0.err), 32'(x.e));
      end else begin
        chk({x.tag, "_a"}, 32'(b1.rdata_a), 32'(x.a));
        chk({x.tag, "_b"}, 32'(b1.rdata_b), 32'(x.b));
        chk({x.tag, "_err"}, 32'(b1.err), 32'(x.e));
      end
    end
  endtask

  initial begin
    // reset, then sweep every address on both ports
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0, 3'(i), 3'(7 - i));
    chk("rst_err0", 32'(b0.err), 0);

    // write then read back on both ports
    step(0, 0, 1, 1, 3, 8'hA5, 0, 0);
    step(0, 0, 1, 0, 0, 0, 3, 3);
    chk("rd3_a0", 32'(b0.rdata_a), 32'h A5);
    chk("rd3_b1", 32'(b1.rdata_b), 32'h A5);

    // bypass on A while B shows the previously stored word
    step(0, 0, 1, 1, 4, 8'h11, 0, 4);
    step(0, 0, 1, 1, 5, 8'h3C, 5, 4);
    chk("byp_a0", 32'(b0.rdata_a), 32'h3C);
    chk("byp_b0", 32'(b0.rdata_b), 32'h11);

    // enable low blocks writes, output updates, and error flagging
    step(0, 0, 1, 1, 2, 8'h22, 2, 2);
    step(0, 0, 0, 1, 2, 8'h99, 1, 0);
    chk("hold_a0", 32'(b0.rdata_a), 32'h22);
    step(0, 0, 0, 1, 6, 8'h55, 3, 3);
    chk("hold_err1", 32'(b1.err), 0);
    step(0, 0, 1, 0, 0, 0, 2, 6);
    chk("hold_rd2", 32'(b0.rdata_a), 32'h22);

    // out-of-range write on the 6-deep bank, clear keeps err, reset drops it
    step(0, 0, 1, 1, 7, 8'h77, 7, 3);
    chk("oor_err1", 32'(b1.err), 1);
    chk("oor_err0", 32'(b0.err), 0);
    chk("oor_a1", 32'(b1.rdata_a), 0);
    step(0, 0, 1, 0, 0, 0, 7, 7);
    step(0, 1, 1, 1, 3, 8'hEE, 3, 3);
    step(0, 0, 1, 0, 0, 0, 3, 5);
    chk("clr_err1", 32'(b1.err), 1);
    chk("clr_a0", 32'(b0.rdata_a), 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("rst_err1", 32'(b1.err), 0);

    // hard-zero word 0, and clear beating a same-cycle write
    step(0, 0, 1, 1, 0, 8'hFF, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("z_a0", 32'(b0.rdata_a), 32'hFF);
    chk("z_a1", 32'(b1.rdata_a), 0);
    chk("z_err1", 32'(b1.err), 0);
    step(0, 0, 1, 1, 1, 8'h44, 0, 0);
    step(0, 1, 1, 1, 1, 8'h77, 1, 1);
    step(0, 0, 1, 0, 0, 0, 1, 1);
    chk("clrw_a0", 32'(b0.rdata_a), 0);

    // random traffic
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), 3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
